tx_result_queue: RTL and testbench
==================================

Name: tx_result_queue

Overview:
- Downstream stage between the ALU result and the UART transmitter.
- Captures one result byte per rising edge of the operation-ready level from the RX command interface.
- Buffers results in a small FIFO and pulses a one-cycle start to the transmitter whenever it is available.
- Lets back-to-back operations arrive while a byte is still on the line, without losing results.

Parameters:
- DATA_BITS, 8, width of each result byte.
- DEPTH, 4, FIFO entries; must be a power of two.
- ADDR_BITS, 2, log2(DEPTH).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- i_result  input  DATA_BITS  ALU result, sampled on push.
- i_result_valid  input  1  operation-ready level from the RX command interface; a push occurs on its 0->1 edge.
- i_tx_available  input  1  transmitter idle flag; high = ready for a new byte.
- o_tx_data  output  DATA_BITS  byte presented to the transmitter; stable from start until the next start.
- o_tx_start  output  1  one-cycle start pulse to the transmitter.
- o_empty  output  1  FIFO empty.
- o_full  output  1  FIFO full.
- o_count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
- o_overflow  output  1  sticky; set when a push is dropped.
- o_state  output  2  FSM state, for debug LEDs.

Behaviour:
- Reset values:
  - o_tx_data=0, o_tx_start=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_state=IDLE.
  - Read and write pointers = 0; edge-detect register = 0.
- Edge detect:
  - Register prev <= i_result_valid every cycle.
  - push_req = i_result_valid & ~prev.
  - A level held high for many cycles yields exactly one push.
- Push:
  - On push_req, write i_result at wr_ptr; increment wr_ptr modulo DEPTH.
  - If FIFO full and no pop in the same cycle: drop the byte, leave the pointer unchanged, set o_overflow.
  - o_overflow clears only on reset.
- Pop: occurs only in the FSM IDLE->WAIT_BUSY transition; increments rd_ptr modulo DEPTH.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - A push while full is accepted if a pop happens in the same cycle.
- Count, empty and full:
  - o_count is a registered counter.
  - o_empty = (count==0); o_full = (count==DEPTH).
  - Both are combinational from the count register.
- FSM (o_state encoding IDLE=0, WAIT_BUSY=1, WAIT_DONE=2; value 3 is illegal and returns to IDLE):
  - IDLE: if !empty && i_tx_available, then on the next edge: o_tx_data <= mem[rd_ptr], o_tx_start <= 1, pop, go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: o_tx_start <= 0. When i_tx_available==0 (transmitter accepted), go to WAIT_DONE.
  - WAIT_DONE: when i_tx_available==1, go to IDLE.
- Latency and pacing:
  - Push sampled at edge k with the FIFO empty and the FSM in IDLE with the TX available gives o_tx_start high during cycle k+1..k+2, i.e. asserted after edge k+1 and cleared after edge k+2.
  - o_tx_start is never high on two consecutive cycles.
  - Minimum spacing between starts is one full transmitter busy period.
- o_tx_data holds its value after the pulse; it is not cleared when the FIFO drains.
- Reset mid-transmission:
  - All state returns to reset values and queued bytes are discarded.
  - The transmitter shares the same reset, so no handshake recovery is needed.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0. Full and empty are distinguished by the count, not by pointer equality.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE, WAIT_BUSY, WAIT_DONE (2-bit).
  - DATA_BITS default.
- Sub-module sync_fifo:
  - Parameters DATA_BITS, DEPTH, ADDR_BITS.
  - Ports push, pop, din, dout (head, combinational read), count, full, empty.
  - Contains the drop-on-full rule; reports a drop via a one-cycle o_drop.
- tx_result_queue keeps the edge detector, FSM, output registers and sticky overflow.

Test Plan:
- Single result: i_result=0x5A, i_result_valid 0->1 held 10 cycles, i_tx_available=1 -> exactly one o_tx_start pulse, 2 cycles after the rise; o_tx_data=0x5A; count 0->1->0.
- Busy transmitter: tx model drops available for 100 cycles after each start; push 0x11, 0x22, 0x33 on separate valid edges 5 cycles apart -> three starts in order 11, 22, 33; each start only after available returns high; count peaks at 2.
- Overflow: i_tx_available=0 held low; push 6 bytes 0x01..0x06 -> o_full after the 4th push, o_count=4, o_overflow=1 after the 5th push; then release available -> outputs 01, 02, 03, 04 only.
- Simultaneous push/pop while full: full FIFO, push aligned with the IDLE pop edge -> byte accepted, count stays 4, o_overflow stays 0.
- Wrap-around: 10 pushes/pops interleaved with a fast tx model -> output order matches input order across pointer wrap; o_empty=1 at the end.
- Reset mid-operation: assert reset during WAIT_DONE with 3 entries queued -> next cycle o_count=0, o_empty=1, o_state=0, o_tx_start=0, o_overflow=0, o_tx_data=0.

Source files
------------

// File: rtl/tx_result_queue_pkg.sv
// Shared definitions for the TX result queue: FSM state encoding and default widths.
// Imported by the FIFO sub-module and the top level.
package tx_result_queue_pkg;

  localparam int DATA_BITS_DEFAULT = 8;
  localparam int DEPTH_DEFAULT     = 4;
  localparam int ADDR_BITS_DEFAULT = 2;

  // Encoding is visible on the debug LEDs, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count and a combinational head read.
// A push while full is dropped unless a pop frees a slot in the same cycle; o_drop flags the loss.
module sync_fifo
  import tx_result_queue_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 o_drop
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Full and empty come from the count, so equal pointers are never ambiguous.
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign o_drop  = push & full & ~do_pop;
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; stale entries are unreachable because reads follow the count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tx_result_queue.sv
// Queues ALU result bytes on each rising edge of the operation-ready level and feeds them
// to the UART transmitter one at a time with a single-cycle start pulse.
module tx_result_queue
  import tx_result_queue_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] i_result,
  input  logic                 i_result_valid,
  input  logic                 i_tx_available,
  output logic [DATA_BITS-1:0] o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_overflow,
  output logic [1:0]           o_state
);

  tx_state_t            state_q;
  tx_state_t            state_d;
  logic                 valid_prev;
  logic                 push_req;
  logic                 pop;
  logic                 drop;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] tx_data_d;
  logic                 tx_start_d;

  // A level held high for many cycles must produce exactly one push.
  assign push_req = i_result_valid & ~valid_prev;

  sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push_req),
    .pop    (pop),
    .din    (i_result),
    .dout   (head),
    .count  (o_count),
    .full   (o_full),
    .empty  (o_empty),
    .o_drop (drop)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_prev <= 1'b0;
      state_q    <= IDLE;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      valid_prev <= i_result_valid;
      state_q    <= state_d;
      o_tx_data  <= tx_data_d;
      o_tx_start <= tx_start_d;
      if (drop) o_overflow <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = o_tx_data;
    tx_start_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!o_empty && i_tx_available) begin
          tx_data_d  = head;
          tx_start_d = 1'b1;
          pop        = 1'b1;
          state_d    = WAIT_BUSY;
        end
      end
      // Wait for the transmitter to take the byte, then for it to finish sending.
      WAIT_BUSY: if (!i_tx_available) state_d = WAIT_DONE;
      WAIT_DONE: if (i_tx_available)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_tx_result_queue.sv
// Directed bench for tx_result_queue: reset, single byte, busy transmitter, overflow,
// push/pop while full, pointer wrap, and reset mid-transmission.
module tb_tx_result_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] i_result = 8'h00;
  logic       i_result_valid = 1'b0;
  logic       i_tx_available = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_empty;
  logic       o_full;
  logic [2:0] o_count;
  logic       o_overflow;
  logic [1:0] o_state;

  int tests = 0;
  int fails = 0;

  // Transmitter model state, advanced once per step.
  bit         tx_auto = 1'b0;
  int         tx_busy_len = 0;
  int         busy_left = 0;
  int         starts = 0;
  bit         prev_start = 1'b0;
  int         max_count = 0;
  logic [7:0] got_q[$];

  tx_result_queue dut (
    .clock          (clock),
    .reset          (reset),
    .i_result       (i_result),
    .i_result_valid (i_result_valid),
    .i_tx_available (i_tx_available),
    .o_tx_data      (o_tx_data),
    .o_tx_start     (o_tx_start),
    .o_empty        (o_empty),
    .o_full         (o_full),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_state        (o_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: sample 1 ns after the edge, record starts, then update the transmitter model.
  task automatic step();
    logic avail_at_edge;
    avail_at_edge = i_tx_available;
    @(posedge clock);
    #1;
    if (o_tx_start) begin
      got_q.push_back(o_tx_data);
      starts++;
      check("start_needs_available", avail_at_edge, 1'b1);
      check("start_not_back_to_back", prev_start, 1'b0);
    end
    if (int'(o_count) > max_count) max_count = int'(o_count);
    if (tx_auto) begin
      if (o_tx_start) begin
        i_tx_available = 1'b0;
        busy_left = tx_busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) i_tx_available = 1'b1;
      end
    end
    prev_start = o_tx_start;
  endtask

  task automatic do_reset(input logic avail);
    i_result_valid = 1'b0;
    i_result = 8'h00;
    i_tx_available = avail;
    tx_auto = 1'b0;
    busy_left = 0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    got_q.delete();
    starts = 0;
    prev_start = 1'b0;
    max_count = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    i_result = b;
    i_result_valid = 1'b1;
    step();
    i_result_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic drain(input int want, input int budget);
    int n = 0;
    while (got_q.size() < want && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic check_got(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] v;
    v = (idx < got_q.size()) ? got_q[idx] : 8'hxx;
    check(tag, v, exp);
  endtask

  initial begin
    // Reset values
    do_reset(1'b0);
    check("rst_tx_data", o_tx_data, 8'h00);
    check("rst_tx_start", o_tx_start, 1'b0);
    check("rst_count", o_count, 3'd0);
    check("rst_empty", o_empty, 1'b1);
    check("rst_full", o_full, 1'b0);
    check("rst_overflow", o_overflow, 1'b0);
    check("rst_state", o_state, 2'd0);

    // Single result, level held high for 10 cycles
    do_reset(1'b1);
    i_result = 8'h5A;
    i_result_valid = 1'b1;
    step();
    check("single_count_1", o_count, 3'd1);
    check("single_no_start_yet", o_tx_start, 1'b0);
    step();
    check("single_start", o_tx_start, 1'b1);
    check("single_data", o_tx_data, 8'h5A);
    check("single_count_0", o_count, 3'd0);
    check("single_state_wait_busy", o_state, 2'd1);
    repeat (8) step();
    check("single_one_pulse", starts, 1);
    check("single_data_held", o_tx_data, 8'h5A);
    check("single_empty", o_empty, 1'b1);
    i_result_valid = 1'b0;
    step();

    // Busy transmitter, 100-cycle busy period
    do_reset(1'b1);
    tx_auto = 1'b1;
    tx_busy_len = 100;
    push_byte(8'h11, 4);
    push_byte(8'h22, 4);
    push_byte(8'h33, 4);
    drain(3, 500);
    check("busy_n_starts", got_q.size(), 3);
    check_got("busy_byte0", 0, 8'h11);
    check_got("busy_byte1", 1, 8'h22);
    check_got("busy_byte2", 2, 8'h33);
    check("busy_peak_count", max_count, 2);

    // Overflow with transmitter held unavailable
    do_reset(1'b0);
    push_byte(8'h01, 1);
    push_byte(8'h02, 1);
    push_byte(8'h03, 1);
    push_byte(8'h04, 1);
    check("ovf_full", o_full, 1'b1);
    check("ovf_count4", o_count, 3'd4);
    check("ovf_not_yet", o_overflow, 1'b0);
    push_byte(8'h05, 1);
    check("ovf_set", o_overflow, 1'b1);
    check("ovf_count_held", o_count, 3'd4);
    push_byte(8'h06, 1);
    i_tx_available = 1'b1;
    tx_auto = 1'b1;
    tx_busy_len = 2;
    drain(4, 200);
    repeat (20) step();
    check("ovf_n_out", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check_got("ovf_order", i, 8'(i + 1));
    check("ovf_sticky", o_overflow, 1'b1);
    check("ovf_empty_end", o_empty, 1'b1);

    // Push aligned with the IDLE pop edge while full
    do_reset(1'b0);
    push_byte(8'hA0, 1);
    push_byte(8'hA1, 1);
    push_byte(8'hA2, 1);
    push_byte(8'hA3, 1);
    i_result = 8'hA4;
    i_result_valid = 1'b1;
    i_tx_available = 1'b1;
    tx_auto = 1'b1;
    tx_busy_len = 2;
    step();
    i_result_valid = 1'b0;
    check("simul_count", o_count, 3'd4);
    check("simul_full", o_full, 1'b1);
    check("simul_no_overflow", o_overflow, 1'b0);
    check("simul_start", o_tx_start, 1'b1);
    check("simul_data", o_tx_data, 8'hA0);
    drain(5, 200);
    check("simul_n_out", got_q.size(), 5);
    for (int i = 0; i < 5; i++) check_got("simul_order", i, 8'hA0 + 8'(i));
    check("simul_overflow_end", o_overflow, 1'b0);

    // Pointer wrap with a fast transmitter
    do_reset(1'b1);
    tx_auto = 1'b1;
    tx_busy_len = 1;
    for (int i = 0; i < 10; i++) push_byte(8'hC0 + 8'(i), 3);
    drain(10, 200);
    repeat (10) step();
    check("wrap_n_out", got_q.size(), 10);
    for (int i = 0; i < 10; i++) check_got("wrap_order", i, 8'hC0 + 8'(i));
    check("wrap_empty", o_empty, 1'b1);
    check("wrap_count", o_count, 3'd0);
    check("wrap_overflow", o_overflow, 1'b0);

    // Reset during WAIT_DONE with 3 entries queued and overflow set
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) push_byte(8'hE0 + 8'(i), 1);
    check("midrst_ovf_pre", o_overflow, 1'b1);
    i_tx_available = 1'b1;
    step();
    check("midrst_start_pre", o_tx_start, 1'b1);
    i_tx_available = 1'b0;
    step();
    check("midrst_state_pre", o_state, 2'd2);
    check("midrst_count_pre", o_count, 3'd3);
    reset = 1'b1;
    step();
    check("midrst_count", o_count, 3'd0);
    check("midrst_empty", o_empty, 1'b1);
    check("midrst_state", o_state, 2'd0);
    check("midrst_start", o_tx_start, 1'b0);
    check("midrst_overflow", o_overflow, 1'b0);
    check("midrst_tx_data", o_tx_data, 8'h00);
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
